mips_multicycle_control: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath (MIPSProcessor). Decodes IR opcode and sequences

---
 rtl/mips_multicycle_control_pkg.sv | 61 ++++++
 rtl/mips_multicycle_control_if.sv | 36 +++
 rtl/mips_multicycle_control_wait_timer.sv | 34 +++
 rtl/mips_multicycle_control.sv | 161 ++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, FSM states,
// datapath select encodings and the bundled control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_e;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_SEXT    = 2'b10;
    localparam logic [1:0] ALUB_SEXT_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_wait_state(state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath bus: decoded inputs, all mux selects / write enables, status pulses.
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, mem_timeout, state_dbg
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, mem_timeout, state_dbg
    );
endinterface

// File: rtl/mips_multicycle_control_wait_timer.sv
// Memory wait watchdog: counts stalled cycles in a request state and flags a
// timeout when the count sits at WAIT_MAX with memory still not ready.
module mips_mem_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic clear,
    output logic timeout
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A ready in the same cycle as the limit drops 'waiting', so completion wins.
    assign timeout = waiting && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || timeout)
            cnt_d = '0;
        else if (waiting)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath with memory-ready handshake and timeout.
// Optional: define MIPS_CTRL_ADDI_EN to decode addi (opcode 001000) through ADDI_EX/ADDI_WB.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    mips_multicycle_control_if.master   bus
);
    state_e state_q, state_d;
    logic   illegal_op_q, illegal_op_d;
    logic   mem_timeout_q, mem_timeout_d;
    logic   waiting, timeout, state_chg;
    ctrl_t  ctrl, ctrl_o;
    logic   unused_zero;

    // zero is consumed by the datapath's PC-enable gate; carried here so the bus is whole.
    assign unused_zero = bus.zero;

    assign waiting   = is_wait_state(state_q) && !bus.mem_ready;
    assign state_chg = (state_d != state_q);

    mips_mem_wait_timer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .waiting (waiting),
        .clear   (state_chg),
        .timeout (timeout)
    );

    always_comb begin
        state_d       = state_q;
        illegal_op_d  = 1'b0;
        mem_timeout_d = timeout;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:       state_d = S_ADDI_EX;
`endif
                    default: begin
                        state_d      = S_FETCH;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:     state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
        // Abandon the stalled request; no IR/PC/register write happens on this path.
        if (timeout)
            state_d = S_FETCH;
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            S_DECODE:   ctrl.alu_src_b = ALUB_SEXT_SH;
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_SEXT;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_SEXT;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB:  ctrl.reg_write = 1'b1;
`endif
            default:    ctrl = '0;
        endcase
    end

    assign ctrl_o = reset ? '0 : ctrl;

    assign bus.pc_write      = ctrl_o.pc_write;
    assign bus.pc_write_cond = ctrl_o.pc_write_cond;
    assign bus.i_or_d        = ctrl_o.i_or_d;
    assign bus.mem_read      = ctrl_o.mem_read;
    assign bus.mem_write     = ctrl_o.mem_write;
    assign bus.ir_write      = ctrl_o.ir_write;
    assign bus.mem_to_reg    = ctrl_o.mem_to_reg;
    assign bus.reg_dst       = ctrl_o.reg_dst;
    assign bus.reg_write     = ctrl_o.reg_write;
    assign bus.alu_src_a     = ctrl_o.alu_src_a;
    assign bus.alu_src_b     = ctrl_o.alu_src_b;
    assign bus.alu_op        = ctrl_o.alu_op;
    assign bus.pc_source     = ctrl_o.pc_source;
    assign bus.illegal_op    = illegal_op_q & ~reset;
    assign bus.mem_timeout   = mem_timeout_q & ~reset;
    assign bus.state_dbg     = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            illegal_op_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            illegal_op_q  <= illegal_op_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: an instruction-level model expands each
// instruction into per-cycle expectations; a monitor compares every cycle.
module tb_mips_multicycle_control;
    localparam int WAIT_MAX = 15;
    localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5,
                   EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, ADDI_EX = 10, ADDI_WB = 11;
    localparam logic [5:0] OPC_R = 6'b000000, OPC_LW = 6'b100011, OPC_SW = 6'b101011,
                           OPC_BEQ = 6'b000100, OPC_J = 6'b000010, OPC_ADDI = 6'b001000;

    typedef struct packed {
        logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       illegal_op, mem_timeout;
        logic [3:0] state;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic [5:0] op;
        logic       z;
        obs_t       exp;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    rec_t drv_q[$];
    obs_t sb_q[$];
    bit   pend_ill, pend_to;
    int   n_chk = 0, n_pass = 0, cyc = 0;

    mips_multicycle_control_if bus ();

    mips_multicycle_control #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Control word each state presents, straight from the state descriptions.
    function automatic obs_t expect_ctrl(input int st, input bit mr);
        obs_t e = '0;
        e.state = 4'(st);
        case (st)
            FETCH:    begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
            DECODE:   e.alu_src_b = 2'b11;
            MEM_ADDR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            MEM_RD:   begin e.mem_read = 1; e.i_or_d = 1; end
            MEM_WB:   begin e.reg_write = 1; e.mem_to_reg = 1; end
            MEM_WR:   begin e.mem_write = 1; e.i_or_d = 1; end
            EXEC:     begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            R_WB:     begin e.reg_write = 1; e.reg_dst = 1; end
            BRANCH:   begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; end
            JUMP:     begin e.pc_write = 1; e.pc_source = 2'b10; end
            ADDI_EX:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            ADDI_WB:  e.reg_write = 1;
            default:  ;
        endcase
        return e;
    endfunction

    task automatic add(input bit rst, input bit mr, input logic [5:0] op, input bit z, input int st);
        rec_t r;
        r.rst = rst; r.mr = mr; r.op = op; r.z = z;
        if (rst) begin
            r.exp = '0;
            r.exp.state = 4'(st);
        end else begin
            r.exp = expect_ctrl(st, mr);
            r.exp.illegal_op  = pend_ill;
            r.exp.mem_timeout = pend_to;
        end
        pend_ill = 0;
        pend_to  = 0;
        drv_q.push_back(r);
    endtask

    // A request stalled for w cycles: completes if w <= WAIT_MAX, else times out.
    task automatic mem_phase(input int st, input logic [5:0] op, input bit z, input int w, output bit ok);
        if (w > WAIT_MAX) begin
            for (int i = 0; i <= WAIT_MAX; i++) add(0, 0, op, z, st);
            pend_to = 1;
            ok = 0;
        end else begin
            for (int i = 0; i < w; i++) add(0, 0, op, z, st);
            add(0, 1, op, z, st);
            ok = 1;
        end
    endtask

    task automatic gen_instr(input logic [5:0] op, input bit z, input int wf, input int wm);
        bit ok;
        mem_phase(FETCH, op, z, wf, ok);
        if (!ok) return;
        add(0, 1'($urandom_range(0, 1)), op, z, DECODE);
        case (op)
            OPC_R:   begin add(0, 1'($urandom_range(0, 1)), op, z, EXEC); add(0, 1'($urandom_range(0, 1)), op, z, R_WB); end
            OPC_LW:  begin
                add(0, 1'($urandom_range(0, 1)), op, z, MEM_ADDR);
                mem_phase(MEM_RD, op, z, wm, ok);
                if (ok) add(0, 1'($urandom_range(0, 1)), op, z, MEM_WB);
            end
            OPC_SW:  begin
                add(0, 1'($urandom_range(0, 1)), op, z, MEM_ADDR);
                mem_phase(MEM_WR, op, z, wm, ok);
            end
            OPC_BEQ: add(0, 1'($urandom_range(0, 1)), op, z, BRANCH);
            OPC_J:   add(0, 1'($urandom_range(0, 1)), op, z, JUMP);
`ifdef MIPS_CTRL_ADDI_EN
            OPC_ADDI: begin add(0, 1'($urandom_range(0, 1)), op, z, ADDI_EX); add(0, 1'($urandom_range(0, 1)), op, z, ADDI_WB); end
`endif
            default: pend_ill = 1;
        endcase
    endtask

    function automatic int rand_wait();
        int r = $urandom_range(0, 9);
        if (r < 6) return 0;
        if (r < 9) return $urandom_range(1, 4);
        return $urandom_range(14, 17);
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] o;
        case ($urandom_range(0, 6))
            0: o = OPC_R;
            1: o = OPC_LW;
            2: o = OPC_SW;
            3: o = OPC_BEQ;
            4: o = OPC_J;
            5: o = OPC_ADDI;
            default: begin
                o = 6'($urandom);
                while (o == OPC_R || o == OPC_LW || o == OPC_SW || o == OPC_BEQ ||
                       o == OPC_J || o == OPC_ADDI) o = 6'($urandom);
            end
        endcase
        return o;
    endfunction

    // Stimulus: build the program, then drive one record per cycle and post its expectation.
    initial begin
        rec_t r;
        reset = 1'b1; bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        pend_ill = 0; pend_to = 0;
        add(1, 0, OPC_R, 0, FETCH);
        add(1, 0, OPC_R, 0, FETCH);
        gen_instr(OPC_R, 0, 0, 0);
        gen_instr(OPC_LW, 0, 0, 3);
        gen_instr(OPC_SW, 0, 0, 0);
        gen_instr(OPC_BEQ, 1, 0, 0);
        gen_instr(OPC_J, 0, 0, 0);
        gen_instr(6'b111111, 0, 0, 0);
        gen_instr(OPC_SW, 0, 0, 16);
        gen_instr(OPC_SW, 0, 0, 15);
        gen_instr(OPC_R, 0, 16, 0);
        gen_instr(OPC_LW, 0, 2, 20);
        gen_instr(OPC_ADDI, 0, 0, 0);
        // Reset lands while a store is stalled in MEM_WR.
        add(0, 1, OPC_SW, 0, FETCH);
        add(0, 1, OPC_SW, 0, DECODE);
        add(0, 1, OPC_SW, 0, MEM_ADDR);
        add(0, 0, OPC_SW, 0, MEM_WR);
        add(0, 0, OPC_SW, 0, MEM_WR);
        add(1, 1, OPC_SW, 0, MEM_WR);
        add(1, 1, OPC_SW, 0, FETCH);
        gen_instr(OPC_R, 0, 1, 0);
        for (int i = 0; i < 60; i++)
            gen_instr(rand_op(), 1'($urandom_range(0, 1)), rand_wait(), rand_wait());
        add(0, 0, OPC_R, 0, FETCH);

        while (drv_q.size() != 0) begin
            @(posedge clk);
            #1;
            r = drv_q.pop_front();
            reset = r.rst;
            bus.mem_ready = r.mr;
            bus.opcode = r.op;
            bus.zero = r.z;
            sb_q.push_back(r.exp);
        end
        @(posedge clk);
        @(posedge clk);
        n_chk++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Monitor: every cycle the controller presents a control word; compare against the queue.
    initial begin
        obs_t got, exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                got = '{pc_write: bus.pc_write, pc_write_cond: bus.pc_write_cond, i_or_d: bus.i_or_d,
                        mem_read: bus.mem_read, mem_write: bus.mem_write, ir_write: bus.ir_write,
                        mem_to_reg: bus.mem_to_reg, reg_dst: bus.reg_dst, reg_write: bus.reg_write,
                        alu_src_a: bus.alu_src_a, alu_src_b: bus.alu_src_b, alu_op: bus.alu_op,
                        pc_source: bus.pc_source, illegal_op: bus.illegal_op,
                        mem_timeout: bus.mem_timeout, state: bus.state_dbg};
                n_chk++;
                if (got === exp) n_pass++;
                else $display("FAIL ctrl_cycle%0d: got state=%0d word=%h, want state=%0d word=%h",
                              cyc, got.state, got, exp.state, exp);
            end
        end
    end
endmodule
